// File: rtl/input_debounce.sv
// Debounced front end for the push-button and DIP-switch PIOs.
// Each raw bit is first synchronised into clk. It then has to hold a new level
// for DEBOUNCE_CYCLES consecutive cycles before the stable output follows it.
// Registered one-cycle event pulses are raised in the same cycle that the new
// stable value first appears on the outputs.

module debounce_channel #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic accept
);

  // DEBOUNCE_CYCLES-1 is the largest count the counter ever holds, so the
  // counter never wraps.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic             stable_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Two-flop synchroniser. It resets to the idle level so that no false
  // mismatch is seen once reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= RESET_VAL;
      sync2_reg <= RESET_VAL;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Counting rules:
  //   - A match with the stable value clears the count, so a single-cycle
  //     interruption restarts counting from zero.
  //   - A mismatch counts up.
  //   - A mismatch seen at the last count is accepted.
  // accept is high in the cycle before the stable value changes.
  always_comb begin
    cnt_next    = cnt_reg;
    stable_next = stable_reg;
    accept      = 1'b0;
    if (sync2_reg != stable_reg) begin
      if (cnt_reg == CNT_LAST) begin
        accept      = 1'b1;
        stable_next = sync2_reg;
        cnt_next    = '0;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end else begin
      cnt_next = '0;
    end
  end

  // Counter and stable-value state. Reset discards any count in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg    <= '0;
      stable_reg <= RESET_VAL;
    end else begin
      cnt_reg    <= cnt_next;
      stable_reg <= stable_next;
    end
  end

  assign stable = stable_reg;

endmodule

module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BTN_W           = 2,
  parameter int SW_W            = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BTN_W-1:0] button_n_raw,
  input  logic [SW_W-1:0]  dipsw_raw,
  output logic [BTN_W-1:0] button_pio_out,
  output logic [SW_W-1:0]  dipsw_pio_out,
  output logic [BTN_W-1:0] button_press,
  output logic [BTN_W-1:0] button_release,
  output logic             dipsw_change
);

  logic [BTN_W-1:0] btn_stable;
  logic [BTN_W-1:0] btn_accept;
  logic [SW_W-1:0]  sw_stable;
  logic [SW_W-1:0]  sw_accept;

  logic [BTN_W-1:0] button_press_reg;
  logic [BTN_W-1:0] button_release_reg;
  logic             dipsw_change_reg;

  genvar gi;

  // Buttons are active-low, so their idle (released) level is 1.
  generate
    for (gi = 0; gi < BTN_W; gi++) begin : g_btn
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VAL      (1'b1)
      ) u_chan (
        .clk   (clk),
        .reset (reset),
        .raw   (button_n_raw[gi]),
        .stable(btn_stable[gi]),
        .accept(btn_accept[gi])
      );
    end
  endgenerate

  // Switches idle at 0.
  generate
    for (gi = 0; gi < SW_W; gi++) begin : g_sw
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VAL      (1'b0)
      ) u_chan (
        .clk   (clk),
        .reset (reset),
        .raw   (dipsw_raw[gi]),
        .stable(sw_stable[gi]),
        .accept(sw_accept[gi])
      );
    end
  endgenerate

  // Event pulses are registered on the same edge that updates the stable
  // value, so each pulse lines up with the new output level. An accepted
  // button that is currently 1 is about to go to 0, which is a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      button_press_reg   <= '0;
      button_release_reg <= '0;
      dipsw_change_reg   <= 1'b0;
    end else begin
      button_press_reg   <= btn_accept & btn_stable;
      button_release_reg <= btn_accept & ~btn_stable;
      dipsw_change_reg   <= |sw_accept;
    end
  end

  assign button_pio_out = btn_stable;
  assign dipsw_pio_out  = sw_stable;
  assign button_press   = button_press_reg;
  assign button_release = button_release_reg;
  assign dipsw_change   = dipsw_change_reg;

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce with DEBOUNCE_CYCLES=4.
// Inputs change just after a falling edge. Every event the stimulus should
// cause is queued along with the edge count at which it must appear. A
// falling-edge monitor pops due entries and checks the pulses and outputs.
// In every other cycle the monitor requires all pulses to be low.

module tb_input_debounce;

  localparam int DC  = 4;
  localparam int LAT = 2 + DC;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] button_n_raw;
  logic [3:0] dipsw_raw;
  logic [1:0] button_pio_out;
  logic [3:0] dipsw_pio_out;
  logic [1:0] button_press;
  logic [1:0] button_release;
  logic       dipsw_change;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;

  typedef struct {
    string      tag;
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
    logic       chg;
    logic [1:0] btn;
    logic [3:0] sw;
  } exp_t;

  exp_t exp_q[$];

  input_debounce #(
    .DEBOUNCE_CYCLES(DC),
    .BTN_W          (2),
    .SW_W           (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .button_n_raw  (button_n_raw),
    .dipsw_raw     (dipsw_raw),
    .button_pio_out(button_pio_out),
    .dipsw_pio_out (dipsw_pio_out),
    .button_press  (button_press),
    .button_release(button_release),
    .dipsw_change  (dipsw_change)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Queue an event. Called right after driving the inputs; the event is due
  // LAT edges later.
  task automatic expect_evt(input string tag, input logic [1:0] p, input logic [1:0] r,
                            input logic c, input logic [1:0] b, input logic [3:0] s);
    exp_t e;
    e.tag   = tag;
    e.cyc   = edge_cnt + LAT;
    e.press = p;
    e.rel   = r;
    e.chg   = c;
    e.btn   = b;
    e.sw    = s;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0 && exp_q[0].cyc <= edge_cnt) begin
      e = exp_q.pop_front();
      chk({e.tag, "_press"},   32'(button_press),   32'(e.press));
      chk({e.tag, "_release"}, 32'(button_release), 32'(e.rel));
      chk({e.tag, "_change"},  32'(dipsw_change),   32'(e.chg));
      chk({e.tag, "_btn"},     32'(button_pio_out), 32'(e.btn));
      chk({e.tag, "_sw"},      32'(dipsw_pio_out),  32'(e.sw));
    end else begin
      chk("idle_pulses", 32'({button_press, button_release, dipsw_change}), 32'h0);
    end
  end

  initial begin
    #100000;
    $fatal(1, "FAIL watchdog expired before end of test");
  end

  initial begin
    reset        = 1'b1;
    button_n_raw = 2'b11;
    dipsw_raw    = 4'b0000;
    tick(3);
    chk("rst_btn", 32'(button_pio_out), 32'h3);
    chk("rst_sw",  32'(dipsw_pio_out),  32'h0);

    // Raw activity during reset must not leak through.
    button_n_raw = 2'b00;
    dipsw_raw    = 4'b1111;
    tick(8);
    chk("rst_hold_btn", 32'(button_pio_out), 32'h3);
    chk("rst_hold_sw",  32'(dipsw_pio_out),  32'h0);
    button_n_raw = 2'b11;
    dipsw_raw    = 4'b0000;
    tick(3);
    reset = 1'b0;
    tick(8);

    // Single press, held: exactly one pulse.
    button_n_raw = 2'b10;
    expect_evt("press0", 2'b01, 2'b00, 1'b0, 2'b10, 4'b0000);
    tick(12);
    chk("hold_btn0", 32'(button_pio_out), 32'h2);

    button_n_raw = 2'b11;
    expect_evt("rel0", 2'b00, 2'b01, 1'b0, 2'b11, 4'b0000);
    tick(10);

    // Glitch: low 3, high 1, then low held.
    button_n_raw = 2'b01;
    tick(3);
    button_n_raw = 2'b11;
    tick(1);
    button_n_raw = 2'b01;
    expect_evt("press1", 2'b10, 2'b00, 1'b0, 2'b01, 4'b0000);
    tick(10);

    button_n_raw = 2'b00;
    expect_evt("press0b", 2'b01, 2'b00, 1'b0, 2'b00, 4'b0000);
    tick(10);

    // Both buttons released together.
    button_n_raw = 2'b11;
    expect_evt("rel_both", 2'b00, 2'b11, 1'b0, 2'b11, 4'b0000);
    tick(10);
    chk("btn_idle", 32'(button_pio_out), 32'h3);

    // Multi-bit switch change gives a single pulse.
    dipsw_raw = 4'b1010;
    expect_evt("sw_1010", 2'b00, 2'b00, 1'b1, 2'b11, 4'b1010);
    tick(10);
    chk("sw_hold", 32'(dipsw_pio_out), 32'hA);

    dipsw_raw = 4'b0000;
    expect_evt("sw_0000", 2'b00, 2'b00, 1'b1, 2'b11, 4'b0000);
    tick(10);

    // Button and switch changes landing on the same edge.
    button_n_raw = 2'b10;
    dipsw_raw    = 4'b0110;
    expect_evt("combo", 2'b01, 2'b00, 1'b1, 2'b10, 4'b0110);
    tick(10);
    button_n_raw = 2'b11;
    dipsw_raw    = 4'b0000;
    expect_evt("combo_back", 2'b00, 2'b01, 1'b1, 2'b11, 4'b0000);
    tick(10);

    // Reset in the middle of a press count: the count is discarded.
    button_n_raw = 2'b10;
    tick(4);
    reset = 1'b1;
    tick(3);
    chk("midrst_btn", 32'(button_pio_out), 32'h3);
    chk("midrst_sw",  32'(dipsw_pio_out),  32'h0);
    reset = 1'b0;
    expect_evt("press_after_rst", 2'b01, 2'b00, 1'b0, 2'b10, 4'b0000);
    tick(10);
    button_n_raw = 2'b11;
    expect_evt("rel_after_rst", 2'b00, 2'b01, 1'b0, 2'b11, 4'b0000);
    tick(10);

    // Reset released with a switch already on.
    reset     = 1'b1;
    dipsw_raw = 4'b0001;
    tick(3);
    chk("rst2_sw", 32'(dipsw_pio_out), 32'h0);
    reset = 1'b0;
    expect_evt("sw_after_rst", 2'b00, 2'b00, 1'b1, 2'b11, 4'b0001);
    tick(12);
    chk("final_sw",    32'(dipsw_pio_out), 32'h1);
    chk("queue_empty", 32'(exp_q.size()),  32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
